// File: rtl/fault_recovery_ctrl_pkg.sv
// Shared types for the decode-stage fault recovery controller.
package fault_recovery_ctrl_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int STATE_W      = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN   = 3'd0,
        ST_FLUSH = 3'd1,
        ST_RETRY = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    // Pipeline control strobes; each one is a pure function of the FSM state.
    typedef struct packed {
        logic stall;
        logic flush;
        logic retry_req;
        logic halt;
    } ctrl_t;

    // Moore decode of the control strobes for a given state.
    function automatic ctrl_t decode_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FLUSH: begin c.stall = 1'b1; c.flush = 1'b1;     end
            ST_RETRY: begin c.stall = 1'b1; c.retry_req = 1'b1; end
            ST_HALT:  begin c.stall = 1'b1; c.halt = 1'b1;      end
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fault_recovery_ctrl_sat_counter.sv
// Saturating incrementer: returns value+1, or value when already all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic [W-1:0] value,
    output logic [W-1:0] result
);

    // Hold at the maximum instead of wrapping back to zero.
    assign result = (&value) ? value : value + W'(1);

endmodule

// File: rtl/fault_recovery_ctrl.sv
// Fault recovery sequencer: stall/flush, re-issue the faulting PC, count
// retries, and escalate to a sticky halt when one instruction keeps faulting.
module fault_recovery_ctrl
    import fault_recovery_ctrl_pkg::*;
#(
    parameter int XLEN         = XLEN_DEFAULT,
    parameter int MAX_RETRY    = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             instr_valid,
    input  logic                             fault_detected,
    input  logic [XLEN-1:0]                  pc,
    input  logic                             retire,
    input  logic                             clear_halt,
    output logic                             stall,
    output logic                             flush,
    output logic                             retry_req,
    output logic [XLEN-1:0]                  retry_pc,
    output logic                             halt,
    output logic [XLEN-1:0]                  fault_pc,
    output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt,
    output logic [CNT_W-1:0]                 fault_total
);

    localparam int RC_W = $clog2(MAX_RETRY + 1);
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t          state;
    ctrl_t           ctrl;
    logic [FC_W-1:0] flush_left;
    logic [CNT_W-1:0] fault_total_inc;
    logic            fault_hit;

    assign fault_hit = instr_valid & fault_detected;

    assign stall     = ctrl.stall;
    assign flush     = ctrl.flush;
    assign retry_req = ctrl.retry_req;
    assign halt      = ctrl.halt;

    sat_counter #(.W(CNT_W)) u_fault_total (
        .value  (fault_total),
        .result (fault_total_inc)
    );

    // Sequencer FSM; control strobes are registered alongside the state they decode.
    always_ff @(posedge clk) begin
        // NOTE: reset lives inside the clocked block, so it only acts on an edge and beats every other input.
        if (rst) begin
            state       <= ST_RUN;
            ctrl        <= '0;
            flush_left  <= '0;
            retry_cnt   <= '0;
            fault_total <= '0;
            fault_pc    <= '0;
            retry_pc    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            case (state)
                ST_RUN: begin
                    if (fault_hit) begin
                        fault_pc    <= pc;
                        retry_pc    <= pc;
                        fault_total <= fault_total_inc;
                        retry_cnt   <= RC_W'(1);
                        flush_left  <= FC_W'(FLUSH_CYCLES - 1);
                        state       <= ST_FLUSH;
                        ctrl        <= decode_ctrl(ST_FLUSH);
                    end
                end
                ST_FLUSH: begin
                    if (flush_left == '0) begin
                        state <= ST_RETRY;
                        ctrl  <= decode_ctrl(ST_RETRY);
                    end else begin
                        flush_left <= flush_left - FC_W'(1);
                    end
                end
                ST_RETRY: begin
                    state <= ST_WAIT;
                    ctrl  <= decode_ctrl(ST_WAIT);
                end
                ST_WAIT: begin
                    // A new fault takes priority over a retire in the same cycle.
                    if (fault_hit) begin
                        fault_pc    <= pc;
                        retry_pc    <= pc;
                        fault_total <= fault_total_inc;
                        if (retry_cnt == RC_W'(MAX_RETRY)) begin
                            state <= ST_HALT;
                            ctrl  <= decode_ctrl(ST_HALT);
                        end else begin
                            retry_cnt  <= retry_cnt + RC_W'(1);
                            flush_left <= FC_W'(FLUSH_CYCLES - 1);
                            state      <= ST_FLUSH;
                            ctrl       <= decode_ctrl(ST_FLUSH);
                        end
                    end else if (retire) begin
                        retry_cnt <= '0;
                        state     <= ST_RUN;
                        ctrl      <= decode_ctrl(ST_RUN);
                    end
                end
                ST_HALT: begin
                    if (clear_halt) begin
                        retry_cnt <= '0;
                        state     <= ST_RUN;
                        ctrl      <= decode_ctrl(ST_RUN);
                    end
                end
                default: begin
                    state <= ST_RUN;
                    ctrl  <= decode_ctrl(ST_RUN);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fault_recovery_ctrl.sv
// Self-checking bench for fault_recovery_ctrl: a cycle model pushes expected
// outputs per driven cycle; each is popped and compared one edge later.
module tb_fault_recovery_ctrl;

    localparam int XLEN         = 32;
    localparam int MAX_RETRY    = 2;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 2;
    localparam int RC_W         = $clog2(MAX_RETRY + 1);
    localparam int TOTAL_MAX    = (1 << CNT_W) - 1;

    localparam int M_RUN = 0, M_FLUSH = 1, M_RETRY = 2, M_WAIT = 3, M_HALT = 4;

    logic              clk;
    logic              rst;
    logic              instr_valid;
    logic              fault_detected;
    logic [XLEN-1:0]   pc;
    logic              retire;
    logic              clear_halt;
    logic              stall;
    logic              flush;
    logic              retry_req;
    logic [XLEN-1:0]   retry_pc;
    logic              halt;
    logic [XLEN-1:0]   fault_pc;
    logic [RC_W-1:0]   retry_cnt;
    logic [CNT_W-1:0]  fault_total;

    typedef struct packed {
        logic             stall;
        logic             flush;
        logic             retry_req;
        logic             halt;
        logic [XLEN-1:0]  retry_pc;
        logic [XLEN-1:0]  fault_pc;
        logic [RC_W-1:0]  retry_cnt;
        logic [CNT_W-1:0] fault_total;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model state
    int              m_st = M_RUN;
    int              m_fc = 0;
    int              m_rc = 0;
    int              m_ft = 0;
    logic [XLEN-1:0] m_fpc = '0;
    logic [XLEN-1:0] m_rpc = '0;

    fault_recovery_ctrl #(
        .XLEN         (XLEN),
        .MAX_RETRY    (MAX_RETRY),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_valid    (instr_valid),
        .fault_detected (fault_detected),
        .pc             (pc),
        .retire         (retire),
        .clear_halt     (clear_halt),
        .stall          (stall),
        .flush          (flush),
        .retry_req      (retry_req),
        .retry_pc       (retry_pc),
        .halt           (halt),
        .fault_pc       (fault_pc),
        .retry_cnt      (retry_cnt),
        .fault_total    (fault_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the reference model by one clock using the inputs now driven.
    task automatic model_step();
        logic hit;
        hit = instr_valid & fault_detected;
        if (rst) begin
            m_st = M_RUN; m_fc = 0; m_rc = 0; m_ft = 0; m_fpc = '0; m_rpc = '0;
        end else begin
            case (m_st)
                M_RUN: if (hit) begin
                    m_fpc = pc; m_rpc = pc;
                    m_ft  = (m_ft < TOTAL_MAX) ? m_ft + 1 : m_ft;
                    m_rc  = 1; m_fc = 1; m_st = M_FLUSH;
                end
                M_FLUSH: if (m_fc == FLUSH_CYCLES) m_st = M_RETRY; else m_fc++;
                M_RETRY: m_st = M_WAIT;
                M_WAIT: begin
                    if (hit) begin
                        m_fpc = pc; m_rpc = pc;
                        m_ft  = (m_ft < TOTAL_MAX) ? m_ft + 1 : m_ft;
                        if (m_rc == MAX_RETRY) m_st = M_HALT;
                        else begin m_rc++; m_fc = 1; m_st = M_FLUSH; end
                    end else if (retire) begin
                        m_rc = 0; m_st = M_RUN;
                    end
                end
                M_HALT: if (clear_halt) begin m_rc = 0; m_st = M_RUN; end
                default: m_st = M_RUN;
            endcase
        end
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        e.stall       = (m_st == M_FLUSH) || (m_st == M_RETRY) || (m_st == M_HALT);
        e.flush       = (m_st == M_FLUSH);
        e.retry_req   = (m_st == M_RETRY);
        e.halt        = (m_st == M_HALT);
        e.retry_pc    = m_rpc;
        e.fault_pc    = m_fpc;
        e.retry_cnt   = RC_W'(m_rc);
        e.fault_total = CNT_W'(m_ft);
        return e;
    endfunction

    // One clock: predict, push, cross the edge, then pop and compare the scoreboard.
    task automatic tick();
        exp_t e;
        exp_t a;
        model_step();
        exp_q.push_back(model_outputs());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        a.stall = stall; a.flush = flush; a.retry_req = retry_req; a.halt = halt;
        a.retry_pc = retry_pc; a.fault_pc = fault_pc;
        a.retry_cnt = retry_cnt; a.fault_total = fault_total;
        n_vec++;
        if (a !== e) begin
            n_miss++;
            $display("FAIL scoreboard t=%0t got st/fl/rr/h=%b%b%b%b rpc=%h fpc=%h rc=%0d ft=%0d expected st/fl/rr/h=%b%b%b%b rpc=%h fpc=%h rc=%0d ft=%0d",
                     $time, a.stall, a.flush, a.retry_req, a.halt, a.retry_pc, a.fault_pc, a.retry_cnt, a.fault_total,
                     e.stall, e.flush, e.retry_req, e.halt, e.retry_pc, e.fault_pc, e.retry_cnt, e.fault_total);
        end
    endtask

    task automatic apply(input logic r, input logic iv, input logic fd, input logic [XLEN-1:0] p,
                         input logic ret, input logic clr);
        rst = r; instr_valid = iv; fault_detected = fd; pc = p; retire = ret; clear_halt = clr;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        apply(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        apply(1'b1, 1'b1, 1'b1, 32'hDEAD_0000, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b1, 32'hDEAD_0004, 1'b0, 1'b0);
        n_vec++;
        if ({stall, flush, retry_req, halt} !== 4'b0000 || fault_total !== '0 || fault_pc !== '0 ||
            retry_pc !== '0 || retry_cnt !== '0) begin
            n_miss++;
            $display("FAIL reset_state got st/fl/rr/h=%b%b%b%b ft=%0d fpc=%h rpc=%h rc=%0d expected all zero",
                     stall, flush, retry_req, halt, fault_total, fault_pc, retry_pc, retry_cnt);
        end
        idle(1);
        n_vec++;
        if (stall !== 1'b0 || fault_total !== '0) begin
            n_miss++;
            $display("FAIL reset_release got stall=%b ft=%0d expected 0 0", stall, fault_total);
        end
    endtask

    task automatic test_recover();
        do_reset();
        apply(1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
        n_vec++;
        if (flush !== 1'b1) begin n_miss++; $display("FAIL recover_flush_c1 got %b expected 1", flush); end
        idle(1);
        n_vec++;
        if (flush !== 1'b1) begin n_miss++; $display("FAIL recover_flush_c2 got %b expected 1", flush); end
        idle(1);
        n_vec++;
        if (retry_req !== 1'b1 || flush !== 1'b0 || retry_pc !== 32'h100) begin
            n_miss++;
            $display("FAIL recover_retry got rr=%b fl=%b rpc=%h expected 1 0 00000100", retry_req, flush, retry_pc);
        end
        idle(1);
        n_vec++;
        if (stall !== 1'b0 || retry_req !== 1'b0) begin
            n_miss++;
            $display("FAIL recover_wait got stall=%b rr=%b expected 0 0", stall, retry_req);
        end
        idle(2);
        apply(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        n_vec++;
        if (retry_cnt !== '0 || fault_total !== 2'd1 || stall !== 1'b0) begin
            n_miss++;
            $display("FAIL recover_done got rc=%0d ft=%0d stall=%b expected 0 1 0", retry_cnt, fault_total, stall);
        end
    endtask

    task automatic test_ignored_window();
        int flush_seen;
        flush_seen = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 1'b0);
            if (flush === 1'b1) flush_seen++;
        end
        idle(2);
        n_vec++;
        if (flush_seen !== 2 || fault_total !== 2'd1) begin
            n_miss++;
            $display("FAIL ignored_window got flush_cycles=%0d ft=%0d expected 2 1", flush_seen, fault_total);
        end
    endtask

    task automatic test_escalate();
        do_reset();
        apply(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
        idle(3);
        apply(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
        idle(3);
        apply(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
        n_vec++;
        if (halt !== 1'b1 || fault_total !== 2'd3 || fault_pc !== 32'h200) begin
            n_miss++;
            $display("FAIL escalate_halt got halt=%b ft=%0d fpc=%h expected 1 3 00000200", halt, fault_total, fault_pc);
        end
        apply(1'b0, 1'b1, 1'b1, 32'h999, 1'b1, 1'b0);
        idle(1);
        n_vec++;
        if (halt !== 1'b1 || stall !== 1'b1 || fault_pc !== 32'h200) begin
            n_miss++;
            $display("FAIL escalate_sticky got halt=%b stall=%b fpc=%h expected 1 1 00000200", halt, stall, fault_pc);
        end
    endtask

    task automatic test_fault_and_retire();
        do_reset();
        apply(1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 1'b0);
        idle(3);
        apply(1'b0, 1'b1, 1'b1, 32'h404, 1'b1, 1'b0);
        n_vec++;
        if (flush !== 1'b1 || retry_cnt !== 2'd2 || fault_pc !== 32'h404) begin
            n_miss++;
            $display("FAIL fault_beats_retire got fl=%b rc=%0d fpc=%h expected 1 2 00000404", flush, retry_cnt, fault_pc);
        end
        idle(3);
        apply(1'b0, 1'b1, 1'b1, 32'h408, 1'b0, 1'b0);
        idle(1);
        apply(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        n_vec++;
        if (halt !== 1'b0 || stall !== 1'b0 || retry_cnt !== '0 || fault_total !== 2'd3) begin
            n_miss++;
            $display("FAIL clear_halt got halt=%b stall=%b rc=%0d ft=%0d expected 0 0 0 3", halt, stall, retry_cnt, fault_total);
        end
    endtask

    task automatic test_saturate_and_reset();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            apply(1'b0, 1'b1, 1'b1, 32'h500 + 32'(k * 4), 1'b0, 1'b0);
            idle(3);
            apply(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        end
        n_vec++;
        if (fault_total !== 2'd3 || fault_pc !== 32'h510) begin
            n_miss++;
            $display("FAIL saturate got ft=%0d fpc=%h expected 3 00000510", fault_total, fault_pc);
        end
        apply(1'b0, 1'b1, 1'b1, 32'h600, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b1, 32'h600, 1'b0, 1'b0);
        n_vec++;
        if (flush !== 1'b0 || stall !== 1'b0 || fault_total !== '0) begin
            n_miss++;
            $display("FAIL reset_mid_flush got fl=%b stall=%b ft=%0d expected 0 0 0", flush, stall, fault_total);
        end
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; fault_detected = 1'b0; pc = '0; retire = 1'b0; clear_halt = 1'b0;
        test_reset();
        test_recover();
        test_ignored_window();
        test_escalate();
        test_fault_and_retire();
        test_saturate_and_reset();
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
